// File: rtl/signed_bcd_converter_pkg.sv
// Shared constants and state encoding for the signed binary-to-BCD converter.
// Imported by the converter top and its digit adjust cell.
package signed_bcd_converter_pkg;

  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

endpackage

// File: rtl/signed_bcd_converter_bcd_add3.sv
// Double-dabble digit correction cell.
// Adds 3 to a BCD digit of 5 or more before the next shift.
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/signed_bcd_converter.sv
// Sequential signed binary-to-BCD converter (shift-add-3).
// Sign and magnitude are split on Start, then 16 shift steps build the digits.
module signed_bcd_converter #(
  parameter int WIDTH  = signed_bcd_converter_pkg::WIDTH,
  parameter int DIGITS = signed_bcd_converter_pkg::DIGITS
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [WIDTH-1:0]      Value,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Negative,
  output logic [4*DIGITS-1:0]   Digits
);

  import signed_bcd_converter_pkg::*;

  state_t               state;
  logic                 sign;
  logic [WIDTH-1:0]     mag;
  logic [4*DIGITS-1:0]  acc;
  logic [4*DIGITS-1:0]  acc_adj;
  logic [CNT_W-1:0]     cnt;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit    (acc[4*g +: 4]),
      .adjusted (acc_adj[4*g +: 4])
    );
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Negative <= 1'b0;
      Digits   <= '0;
      sign     <= 1'b0;
      mag      <= '0;
      acc      <= '0;
      cnt      <= '0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Start) begin
            // 0x8000 negates to itself, which is 32768 read as unsigned
            sign  <= Value[WIDTH-1];
            mag   <= Value[WIDTH-1] ? WIDTH'(-Value) : Value;
            acc   <= '0;
            cnt   <= '0;
            Busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          {acc, mag} <= {acc_adj, mag} << 1;
          cnt        <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1))
            state <= FINISH;
        end
        FINISH: begin
          Digits   <= acc;
          Negative <= sign;
          Done     <= 1'b1;
          Busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_bcd_converter.sv
// Bench for signed_bcd_converter: cycle-level behavioural model plus
// directed literal cases and randomized traffic.
module tb_signed_bcd_converter;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [15:0] Value = '0;
  logic        Busy;
  logic        Done;
  logic        Negative;
  logic [19:0] Digits;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  signed_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .Value    (Value),
    .Busy     (Busy),
    .Done     (Done),
    .Negative (Negative),
    .Digits   (Digits)
  );

  always #5 Clock = ~Clock;

  function automatic logic [19:0] to_bcd(input int m);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  // Model: a conversion occupies 17 cycles after acceptance.
  int          m_left = 0;
  int          m_val  = 0;
  bit          m_done = 1'b0;
  bit          m_neg  = 1'b0;
  logic [19:0] m_dig  = '0;

  always @(posedge Clock) begin
    if (Reset) begin
      m_left = 0;
      m_done = 1'b0;
      m_neg  = 1'b0;
      m_dig  = '0;
    end else begin
      m_done = 1'b0;
      if (m_left == 0) begin
        if (Start) begin
          m_val  = int'($signed(Value));
          m_left = 17;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_dig  = to_bcd(m_val < 0 ? -m_val : m_val);
          m_neg  = (m_val < 0);
          m_done = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [19:0] act,
                     input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clock) begin
    if (chk_en) begin
      chk("busy",     20'(Busy),     20'(m_left != 0));
      chk("done",     20'(Done),     20'(m_done));
      chk("negative", 20'(Negative), 20'(m_neg));
      chk("digits",   Digits,        m_dig);
    end
  end

  // Called just after the accepting edge; returns cycles until Done seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (Done !== 1'b1 && lat < 40) begin
      @(negedge Clock);
      lat++;
    end
  endtask

  task automatic run(input logic [15:0] v, input logic [19:0] exp_d,
                     input bit exp_n, input string name);
    int lat;
    @(negedge Clock);
    Start = 1'b1;
    Value = v;
    @(negedge Clock);
    Start = 1'b0;
    wait_done(lat);
    chk({name, " latency"}, 20'(lat), 20'd17);
    chk({name, " digits"}, Digits, exp_d);
    chk({name, " neg"}, 20'(Negative), 20'(exp_n));
  endtask

  initial begin
    int lat;
    int pulses;
    repeat (3) @(negedge Clock);
    Start = 1'b1;
    Value = 16'd9;
    @(negedge Clock);
    Reset = 1'b0;
    Start = 1'b0;
    chk_en = 1'b1;
    chk("reset busy", 20'(Busy), 20'd0);
    chk("reset digits", Digits, 20'd0);
    @(negedge Clock);
    chk("start in reset dropped", 20'(Busy), 20'd0);

    run(16'd33,   20'h00033, 1'b0, "v33");
    run(16'hFFDF, 20'h00033, 1'b1, "vm33");
    run(16'hFFFF, 20'h00001, 1'b1, "vm1");
    run(16'h8000, 20'h32768, 1'b1, "vmin");
    run(16'h7FFF, 20'h32767, 1'b0, "vmax");
    run(16'h0000, 20'h00000, 1'b0, "vzero");

    // Start while busy is ignored; Start in the Done cycle is accepted
    @(negedge Clock);
    Start = 1'b1;
    Value = 16'd100;
    @(negedge Clock);
    Start = 1'b0;
    repeat (3) @(negedge Clock);
    Start = 1'b1;
    Value = 16'd5;
    @(negedge Clock);
    Start = 1'b0;
    wait_done(lat);
    chk("busy start latency", 20'(lat + 4), 20'd17);
    chk("busy start digits", Digits, 20'h00100);
    Start = 1'b1;
    Value = 16'd7;
    @(negedge Clock);
    Start = 1'b0;
    wait_done(lat);
    chk("done-cycle start latency", 20'(lat), 20'd17);
    chk("done-cycle start digits", Digits, 20'h00007);

    // Abort by reset mid-conversion
    run(16'hFFDF, 20'h00033, 1'b1, "pre-abort");
    @(negedge Clock);
    Start = 1'b1;
    Value = 16'd999;
    @(negedge Clock);
    Start = 1'b0;
    repeat (7) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    chk("abort busy", 20'(Busy), 20'd0);
    chk("abort done", 20'(Done), 20'd0);
    chk("abort digits", Digits, 20'd0);
    chk("abort neg", 20'(Negative), 20'd0);
    pulses = 0;
    repeat (20) begin
      @(negedge Clock);
      if (Done === 1'b1) pulses++;
    end
    chk("abort no done", 20'(pulses), 20'd0);
    run(16'd12345, 20'h12345, 1'b0, "v12345");

    // Quotients from the upstream divider
    run(16'(255 / 10),       20'h00025, 1'b0, "q255_10");
    run(16'(12345 / 123),    20'h00100, 1'b0, "q12345_123");
    run(16'(-100 / 3),       20'h00033, 1'b1, "qm100_3");
    run(16'(100 / -3),       20'h00033, 1'b1, "q100_m3");
    run(16'(-32768 / 256),   20'h00128, 1'b1, "qm32768_256");

    // Random traffic, model checks every cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clock);
      Start = ($urandom_range(3) == 0);
      Value = 16'($urandom);
      Reset = ($urandom_range(80) == 0);
    end
    @(negedge Clock);
    Start = 1'b0;
    Reset = 1'b0;
    repeat (25) @(negedge Clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/signed_bcd_converter.md
SIGNED_BCD_CONVERTER -- requirements
Module: signed_bcd_converter

Interface
REQ-001 Parameter: WIDTH, 16, binary operand width; only 16 is supported and verified.
REQ-002 Parameter: DIGITS, 5, number of BCD output digits (covers magnitude up to 32768).
REQ-003 Clock  input  1  single clock; all state updates occur on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  request to convert Value; level sampled on the rising edge.
REQ-006 Value  input  WIDTH  two's-complement operand (the divider Quotient).
REQ-007 Busy  output  1  high while a conversion is in progress.
REQ-008 Done  output  1  one-cycle pulse marking that Negative and Digits are valid.
REQ-009 Negative  output  1  sign of the converted operand; 1 means Value < 0.
REQ-010 Digits  output  4*DIGITS  packed BCD magnitude, most significant digit in bits [19:16].

Function
REQ-011 States SHALL be IDLE, SHIFT and FINISH, with no other reachable state.
REQ-012 In IDLE with Start=1 at an edge, the block SHALL capture sign = Value[15] and magnitude = |Value| as 16-bit unsigned, clear the BCD accumulator and the iteration counter, and enter SHIFT.
REQ-013 Value = 0x8000 SHALL produce magnitude 32768 with no overflow indication.
REQ-014 Each SHIFT edge SHALL add 3 to every accumulator digit >= 5, then shift {accumulator, magnitude} left by one bit and increment the counter.
REQ-015 After the 16th SHIFT edge, the block SHALL enter FINISH.
REQ-016 On the FINISH edge, the block SHALL load Digits and Negative from the accumulator and sign, drive Done=1 for exactly the following cycle, and return to IDLE.
REQ-017 Latency: for Start accepted at edge k, Done SHALL be high from edge k+17 to edge k+18.
REQ-018 Busy SHALL be high in SHIFT and FINISH and low in IDLE.
REQ-019 Start while Busy=1 SHALL be ignored, with no effect on the conversion in flight.
REQ-020 Start sampled in the cycle Done is high SHALL be accepted, since the state is IDLE.
REQ-021 Digits and Negative SHALL hold their last result until the next FINISH edge, and SHALL NOT change during a later conversion.
REQ-022 Negative SHALL be 0 when Value = 0; negative zero SHALL never be reported.
REQ-023 Each digit of Digits SHALL always be in the range 0-9.

Reset
REQ-024 Reset=1 at an edge SHALL force IDLE and clear Busy, Done, Negative, Digits, the accumulator and the counter to 0.
REQ-025 Reset has priority over Start; Start during Reset SHALL be dropped.
REQ-026 Reset mid-conversion SHALL abort it, with no Done pulse for the aborted operand.

Structure
REQ-027 A shared package SHALL hold WIDTH, DIGITS, the counter width (5 bits) and the state enumeration (IDLE, SHIFT, FINISH).
REQ-028 One combinational sub-module, bcd_add3 (4-bit in, 4-bit out, adds 3 when input >= 5), SHALL be instantiated once per digit.
REQ-029 Value SHALL connect directly to the divider Quotient, and Start SHALL connect to the divider Done pulse.

Verification
REQ-030 Value=16'd33 with a Start pulse -> Done exactly 17 cycles later, Digits=20'h00033, Negative=0.
REQ-031 Value=-16'sd33 (0xFFDF) -> Digits=20'h00033, Negative=1; Value=0xFFFF -> Digits=20'h00001, Negative=1.
REQ-032 Value=0x8000 -> Digits=20'h32768, Negative=1; Value=0x7FFF -> Digits=20'h32767, Negative=0; Value=0 -> Digits=0, Negative=0.
REQ-033 Start re-asserted with Value=5 at cycle 4 of a conversion of 100 -> result 00100, exactly one Done pulse; Start in the Done cycle with Value=7 -> next result 00007.
REQ-034 Reset asserted at cycle 8 of a conversion -> Busy=0 and all outputs 0 on the next cycle, no Done pulse; a following Start with 12345 -> Digits=20'h12345.
REQ-035 Chained with the divider: 255/10, 12345/123, -100/3, 100/-3 and -32768/256 -> Digits/Negative equal to 00025/0, 00100/0, 00033/1, 00033/1 and 00128/1.
